// File: rtl/torus_port_arbiter.sv
// torus_port_arbiter: round-robin, wormhole-locked, credit-gated output-port allocator for a torus node.
// Optional lock watchdog and sticky timeout_flag port enabled by defining ARB_TIMEOUT_EN.
`default_nettype none

module torus_port_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int FLIT_W  = 8,
  parameter int CREDITS = 4,
  parameter int CRED_W  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN-1:0]        tail,
  input  logic [NUM_IN*FLIT_W-1:0] flit_in,
  input  logic                     credit_in,
  output logic [NUM_IN-1:0]        grant,
  output logic [NUM_IN-1:0]        pop,
  output logic [FLIT_W-1:0]        flit_out,
  output logic                     valid_out,
  output logic [CRED_W-1:0]        credit_cnt,
  output logic                     cred_err
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                     timeout_flag
`endif
);

  localparam int PTR_W = $clog2(NUM_IN);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_IN-1:0]   r_grant, w_grant_nxt;
  logic [PTR_W-1:0]    r_rr_ptr, w_rr_nxt;
  logic [FLIT_W-1:0]   r_flit_out;
  logic                r_valid_out;
  logic [CRED_W-1:0]   r_credit_cnt;
  logic                r_cred_err;

  logic [PTR_W-1:0]    w_winner;
  logic                w_any_req;
  logic [PTR_W-1:0]    w_owner;
  logic [PTR_W-1:0]    w_owner_inc;
  logic [FLIT_W-1:0]   w_owner_flit;
  logic [NUM_IN-1:0]   w_pop;
  logic                w_pop_any;
  logic                w_pop_tail;
  logic                w_timeout;

  // Rotating priority search: first requester at or above rr_ptr, wrapping.
  always_comb begin : p_arb
    logic [PTR_W:0] w_sum;
    w_winner  = '0;
    w_any_req = 1'b0;
    w_sum     = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_IN)) w_sum = w_sum - (PTR_W+1)'(NUM_IN);
      if (!w_any_req && req[w_sum[PTR_W-1:0]]) begin
        w_any_req = 1'b1;
        w_winner  = w_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_owner      = '0;
    w_owner_flit = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grant[i]) begin
        w_owner      = PTR_W'(i);
        w_owner_flit = flit_in[i*FLIT_W +: FLIT_W];
      end
    end
  end

  assign w_owner_inc = (w_owner == PTR_W'(NUM_IN-1)) ? '0 : w_owner + 1'b1;
  assign w_pop       = r_grant & req & {NUM_IN{r_credit_cnt != '0}};
  assign w_pop_any   = |w_pop;
  assign w_pop_tail  = |(w_pop & tail);

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT+1);
  logic [WD_W-1:0] r_wdog;
  logic            r_timeout_flag;

  assign w_timeout = (r_state == ST_BUSY) && !w_pop_any && (r_wdog == WD_W'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog         <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (r_state != ST_BUSY || w_pop_any || w_timeout) r_wdog <= '0;
      else                                              r_wdog <= r_wdog + 1'b1;
      if (w_timeout) r_timeout_flag <= 1'b1;
    end
  end

  assign timeout_flag = r_timeout_flag;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = NUM_IN'(1) << w_winner;
        end
      end
      ST_BUSY: begin
        // Lock is held across req gaps; only a tail pop (or watchdog) frees it.
        if (w_pop_tail || w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = w_owner_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flit_out   <= '0;
      r_valid_out  <= 1'b0;
      r_credit_cnt <= CRED_W'(CREDITS);
      r_cred_err   <= 1'b0;
    end else begin
      r_valid_out <= w_pop_any;
      if (w_pop_any) r_flit_out <= w_owner_flit;
      // Simultaneous pop and returned credit cancel out.
      if (w_pop_any && !credit_in) begin
        r_credit_cnt <= r_credit_cnt - 1'b1;
      end else if (credit_in && !w_pop_any) begin
        if (r_credit_cnt == CRED_W'(CREDITS)) r_cred_err   <= 1'b1;
        else                                  r_credit_cnt <= r_credit_cnt + 1'b1;
      end
    end
  end

  assign grant      = r_grant;
  assign pop        = w_pop;
  assign flit_out   = r_flit_out;
  assign valid_out  = r_valid_out;
  assign credit_cnt = r_credit_cnt;
  assign cred_err   = r_cred_err;

endmodule

`default_nettype wire

// File: tb/tb_torus_port_arbiter.sv
// tb_torus_port_arbiter: directed and random stimulus against a packet-level reference model.
`default_nettype none

module tb_torus_port_arbiter;

  localparam int N       = 5;
  localparam int W       = 8;
  localparam int CREDITS = 4;
  localparam int CW      = 3;
  localparam int TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, tail, grant, pop;
  logic [N*W-1:0] flit_in;
  logic           credit_in;
  logic [W-1:0]   flit_out;
  logic           valid_out;
  logic [CW-1:0]  credit_cnt;
  logic           cred_err;
`ifdef ARB_TIMEOUT_EN
  logic           timeout_flag;
`endif

  torus_port_arbiter #(
    .NUM_IN(N), .FLIT_W(W), .CREDITS(CREDITS), .CRED_W(CW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .flit_in(flit_in),
    .credit_in(credit_in), .grant(grant), .pop(pop), .flit_out(flit_out),
    .valid_out(valid_out), .credit_cnt(credit_cnt), .cred_err(cred_err)
`ifdef ARB_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-requester packet sources: {tail, data}
  logic [8:0] q[N][$];
  bit         hold[N];

  bit         m_known;
  int         m_owner, m_rr, m_cred, m_wd;
  bit         m_err, m_valid, m_to;
  logic [7:0] m_flit;

  bit         rec_order;
  logic [N-1:0] last_grant;
  int         gorder[$];

  int         vcount;
  logic [7:0] d[6];
  int         exp_order[6] = '{0, 1, 2, 3, 4, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = (q[i].size() > 0) && !hold[i];
      if (q[i].size() > 0) begin
        tail[i]          = q[i][0][8];
        flit_in[i*W +: W] = q[i][0][7:0];
      end else begin
        tail[i]          = 1'b0;
        flit_in[i*W +: W] = W'($urandom);
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] ep;
    if (!m_known) return;
    ep = '0;
    if (m_owner >= 0 && req[m_owner] && m_cred > 0) ep = onehot(m_owner);
    chk("grant", grant, onehot(m_owner));
    chk("pop", pop, ep);
    chk("valid_out", valid_out, m_valid);
    chk("flit_out", flit_out, m_flit);
    chk("credit_cnt", credit_cnt, m_cred);
    chk("cred_err", cred_err, m_err);
`ifdef ARB_TIMEOUT_EN
    chk("timeout_flag", timeout_flag, m_to);
`endif
    if (rec_order && grant != last_grant && grant != '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) gorder.push_back(i);
    end
    last_grant = grant;
  endtask

  // Reference: one clock edge of the arbiter described in terms of owner/pointer/credit counts.
  task automatic step_model();
    bit popped;
    bit found;
    int own;
    own = m_owner;
    if (rst) begin
      m_known = 1; m_owner = -1; m_rr = 0; m_cred = CREDITS; m_err = 0;
      m_valid = 0; m_flit = '0; m_wd = 0; m_to = 0;
      for (int i = 0; i < N; i++) begin
        q[i].delete();
        hold[i] = 0;
      end
      return;
    end
    popped = (own >= 0) && req[own] && (m_cred > 0);
    if (own < 0) begin
      m_valid = 0;
      m_wd    = 0;
      found   = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_rr + k) % N]) begin
          found   = 1;
          m_owner = (m_rr + k) % N;
        end
      end
    end else begin
      m_valid = popped;
      if (popped) begin
        m_flit = q[own][0][7:0];
        m_wd   = 0;
        if (q[own][0][8]) begin
          m_rr    = (own + 1) % N;
          m_owner = -1;
        end
      end
`ifdef ARB_TIMEOUT_EN
      else begin
        m_wd++;
        if (m_wd == TIMEOUT) begin
          m_to = 1; m_rr = (own + 1) % N; m_owner = -1; m_wd = 0;
        end
      end
`endif
    end
    if (popped && !credit_in) m_cred--;
    else if (credit_in && !popped) begin
      if (m_cred == CREDITS) m_err = 1;
      else m_cred++;
    end
    if (popped) void'(q[own].pop_front());
  endtask

  task automatic tick();
    drive();
    #1;
    check_outputs();
    step_model();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; credit_in = 1'b0; req = '0; tail = '0; flit_in = '0;
    m_known = 0; m_owner = -1; rec_order = 0; last_grant = '0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Idle after reset
    repeat (6) tick();
    chk("idle_grant", grant, 0);
    chk("idle_credits", credit_cnt, 4);

    // Three-flit packet from requester 1, no credit returns
    q[1].push_back({1'b0, 8'hA1});
    q[1].push_back({1'b0, 8'hA2});
    q[1].push_back({1'b1, 8'hA3});
    repeat (8) tick();
    chk("pkt_credits", credit_cnt, 1);
    chk("pkt_grant_released", grant, 0);
    chk("pkt_last_flit", flit_out, 8'hA3);

    // Pointer now at 2: requester 3 must beat requester 0
    q[0].push_back({1'b1, 8'h10});
    q[3].push_back({1'b1, 8'h30});
    credit_in = 1'b1;
    tick();
    chk("rr_after_tail", grant, 5'b01000);
    repeat (6) tick();
    credit_in = 1'b0;

    // All requesters busy, single-flit packets, credit every cycle
    rst = 1'b1; tick(); rst = 1'b0;
    credit_in = 1'b1;
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 4; r++) q[i].push_back({1'b1, 8'($urandom)});
    gorder.delete();
    rec_order = 1;
    repeat (12) tick();
    rec_order = 0;
    for (int j = 0; j < 6; j++)
      chk("rr_order", (gorder.size() > j) ? gorder[j] : -1, exp_order[j]);
    chk("rr_credits_flat", credit_cnt, 4);
    credit_in = 1'b0;

    // Credit exhaustion stalls a 6-flit packet
    rst = 1'b1; tick(); rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      d[j] = 8'($urandom);
      q[2].push_back({(j == 5), d[j]});
    end
    vcount = 0;
    repeat (12) begin
      tick();
      if (valid_out === 1'b1) vcount++;
    end
    chk("stall_flits_out", vcount, 4);
    chk("stall_credits", credit_cnt, 0);
    chk("stall_grant", grant, 5'b00100);
    chk("stall_pop", pop, 0);
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    tick();
    chk("resume_valid", valid_out, 1);
    chk("resume_flit", flit_out, d[4]);
    credit_in = 1'b1;
    repeat (5) tick();
    credit_in = 1'b0;

    // Credit overflow sets the sticky error; reset clears it
    rst = 1'b1; tick(); rst = 1'b0;
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    chk("ovf_err", cred_err, 1);
    chk("ovf_credits", credit_cnt, 4);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_err_cleared", cred_err, 0);

    // Owner 3 drops req mid-packet while requester 4 waits
    for (int j = 0; j < 4; j++) q[3].push_back({(j == 3), 8'h30 + 8'(j)});
    for (int j = 0; j < 5; j++) q[4].push_back({(j == 4), 8'h40 + 8'(j)});
    tick(); tick();
    hold[3] = 1;
    repeat (20) tick();
`ifdef ARB_TIMEOUT_EN
    chk("wd_flag", timeout_flag, 1);
    chk("wd_next_owner", grant, 5'b10000);
`else
    chk("lock_held", grant, 5'b01000);
`endif
    hold[3] = 0;

    // Random traffic
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) begin
        int r, len;
        r   = $urandom_range(0, N-1);
        len = $urandom_range(1, 4);
        if (q[r].size() < 8)
          for (int j = 0; j < len; j++) q[r].push_back({(j == len-1), 8'($urandom)});
      end
      credit_in = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; credit_in = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/torus_port_arbiter.md
Name: torus_port_arbiter

Overview:
- Output-port switch allocator for one direction of a torus router node.
- Shares a single outgoing 8-bit link among five requesters: local, east, west, north and south input buffers.
- Arbitration is round-robin at packet granularity, with wormhole locking from the winner's first flit until its tail flit.
- Downstream flow control is credit-based, so the link never overruns the neighbour's input buffer.
- One instance sits per output direction inside each torus node; the inter-node link register stage is unchanged.

Parameters:
- NUM_IN, 5, number of requesters (index 0=local, 1=E, 2=W, 3=N, 4=S).
- FLIT_W, 8, flit width in bits.
- CREDITS, 4, downstream buffer depth; also the reset value of the credit counter.
- CRED_W, 3, credit counter width; must satisfy 2^CRED_W > CREDITS.
- TIMEOUT, 16, lock watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_IN  per-requester flit-valid.
- tail  input  NUM_IN  per-requester "current flit is last of packet".
- flit_in  input  NUM_IN*FLIT_W  packed flits; requester i occupies bits [i*FLIT_W +: FLIT_W].
- credit_in  input  1  one-cycle pulse: downstream freed one buffer slot.
- grant  output  NUM_IN  one-hot lock owner; all zero when idle.
- pop  output  NUM_IN  combinational one-hot: owner's flit is consumed at this edge.
- flit_out  output  FLIT_W  registered outgoing flit.
- valid_out  output  1  registered, high for one cycle per transferred flit.
- credit_cnt  output  CRED_W  current available credits.
- cred_err  output  1  sticky flag: credit_in received while credit_cnt==CREDITS.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, grant=0, rr_ptr=0, flit_out=0, valid_out=0.
  - credit_cnt=CREDITS, cred_err=0, watchdog=0.
  - Reset applied mid-packet drops the lock; the interrupted packet is not resumed.
- States: IDLE, BUSY.
- IDLE:
  - If any req bit is set, the winner is the first set req index found by searching upward from rr_ptr, wrapping modulo NUM_IN.
  - Next edge: grant<=onehot(winner), state<=BUSY.
  - No flit moves in the IDLE cycle, so arbitration latency is 1 cycle.
  - Credit count does not gate arbitration.
- BUSY:
  - pop[o] = grant[o] & req[o] & (credit_cnt!=0).
  - On pop: flit_out<=flit_in[o], valid_out<=1, credit_cnt decrements.
  - Otherwise valid_out<=0 and flit_out holds its value.
  - Pop with tail[o]=1: state<=IDLE, grant<=0, rr_ptr<=(o+1) mod NUM_IN. The next packet cannot start before the following cycle.
  - req[o] low without a tail: the lock is held and other requesters stay blocked (wormhole).
- Credits:
  - Pop and credit_in in the same cycle: count unchanged.
  - credit_in alone at CREDITS: count saturates and cred_err<=1.
  - Pop is impossible at 0 credits, so the counter never underflows.
- Throughput: one flit per cycle while credits are available. Latency from pop to valid_out is 1 cycle.
- Fairness: a requester waits at most NUM_IN-1 packets after it asserts req.
- Requests from non-owners while BUSY are ignored and never popped.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - In BUSY, the watchdog counts cycles without a pop and clears on pop.
  - When it reaches TIMEOUT: state<=IDLE, grant<=0, rr_ptr<=owner+1.
  - An added output, timeout_flag (1 bit, sticky, cleared only by rst), is set.
- ARB_TIMEOUT_EN undefined:
  - No watchdog and no timeout_flag port; the lock is held indefinitely.

Test Plan:
- Reset release with all req=0 → grant=0, valid_out=0, credit_cnt=4 indefinitely.
- req[1] carries 3 flits A1,A2,A3 (tail on A3), credit_in never pulsed → grant=00010 one cycle after req; flit_out A1,A2,A3 on consecutive cycles; credit_cnt 4→1; grant=0 after A3; rr_ptr=2.
- req=11111 continuously, each requester sending 1-flit packets, credit_in pulsed every cycle → grant order 0,1,2,3,4,0; one packet every 2 cycles; credit_cnt stays at 4.
- CREDITS=4; requester 2 sends a 6-flit packet; no credit_in until valid_out has pulsed 4 times, then one pulse → exactly 4 flits out, pop=0 while credit_cnt=0, flit 5 follows 1 cycle after the pulse; grant held throughout.
- Pulse credit_in at credit_cnt=4 → cred_err=1, credit_cnt stays 4; rst then clears it.
- With ARB_TIMEOUT_EN: owner 3 drops req mid-packet → timeout_flag=1 and grant=0 after 16 idle cycles; requester 4 is granted next. Without the macro: grant stays at 01000.
